window_3x3_gen: RTL and testbench

- Upstream neighbour of median_filter in the image-processing chain.
- Accepts a raster-order 8-bit pixel stream with a valid strobe.
- Buffers two previous image lines and emits, per accepted pixel, the full 3x3 neighbourhood as one packed 72-bit word. The median core sorts this word.
- Only interior windows are emitted (no border padding). Output image size is (IMG_W-2)x(IMG_H-2).

---
 rtl/img_pkg.sv | 10 +
 rtl/window_3x3_gen_line_buf.sv | 24 ++
 rtl/window_3x3_gen.sv | 90 +++++++++
 tb/tb_window_3x3_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline types and constants for window_3x3_gen and median_filter.
package img_pkg;
  localparam int DW         = 8;
  localparam int KSZ        = 3;
  localparam int WIN_N      = KSZ * KSZ;
  localparam int CENTER_IDX = 4;

  typedef logic [DW-1:0]       pix_t;
  typedef logic [WIN_N*DW-1:0] win_t;
endpackage

// File: rtl/window_3x3_gen_line_buf.sv
// Single-port line memory: one synchronous write, combinational read at the same address.
module line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[addr];
  end
endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator; emits interior windows only.
module window_3x3_gen
  import img_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     dat_i,
  input  logic              val_i,
  output logic [WIN_N*DW-1:0] win_o,
  output logic              val_o,
  output logic              eof_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [WIN_N*DW-1:0]   win_q, win_d;
  logic                  val_q, val_d;
  logic                  eof_q, eof_d;
  logic [2*DW-1:0]       lb_rd, lb_wd;

  // Upper half is lb1 (row r-2), lower half is lb0 (row r-1); one write cascades both.
  line_buf #(
    .DEPTH(IMG_W),
    .WIDTH(2 * DW),
    .AW   (CW)
  ) u_lb (
    .clk  (clk),
    .we   (val_i),
    .addr (col_q),
    .wdata(lb_wd),
    .rdata(lb_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    val_d = 1'b0;
    eof_d = 1'b0;
    lb_wd = {lb_rd[DW-1:0], dat_i};
    if (val_i) begin
      val_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      eof_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int unsigned i = 0; i < KSZ; i++) begin
        for (int unsigned j = 0; j + 1 < KSZ; j++) begin
          win_d[DW*(KSZ*i+j) +: DW] = win_q[DW*(KSZ*i+j+1) +: DW];
        end
      end
      win_d[DW*(KSZ*0+2) +: DW] = lb_rd[2*DW-1:DW];
      win_d[DW*(KSZ*1+2) +: DW] = lb_rd[DW-1:0];
      win_d[DW*(KSZ*2+2) +: DW] = dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      val_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      val_q <= val_d;
      eof_q <= eof_d;
    end
  end

  assign win_o = win_q;
  assign val_o = val_q;
  assign eof_o = eof_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed and randomised checks of window_3x3_gen at 4x4 and 5x6 frame sizes.
module tb_window_3x3_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d4 = '0, d5 = '0;
  logic        v4 = 1'b0, v5 = 1'b0;
  logic [71:0] w4, w5;
  logic        vo4, vo5, eo4, eo5;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.DW(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst_n(rst_n), .dat_i(d4), .val_i(v4),
    .win_o(w4), .val_o(vo4), .eof_o(eo4)
  );

  window_3x3_gen #(.DW(8), .IMG_W(5), .IMG_H(6)) u56 (
    .clk(clk), .rst_n(rst_n), .dat_i(d5), .val_i(v5),
    .win_o(w5), .val_o(vo5), .eof_o(eo5)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel=0 drives the 4x4 instance, sel=1 the 5x6 instance; outputs sampled 1ns after the edge.
  task automatic step(input bit sel, input logic v, input logic [7:0] d);
    @(negedge clk);
    v4 = 1'b0; v5 = 1'b0;
    if (sel) begin v5 = v; d5 = d; end
    else     begin v4 = v; d4 = d; end
    @(posedge clk);
    #1;
  endtask

  // First-window offsets within a 4-wide raster, window index 0..8.
  function automatic logic [71:0] exp4(input int base);
    int tbl [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [71:0] w;
    w = '0;
    for (int j = 0; j < 9; j++) w[8*j +: 8] = 8'(base + tbl[j]);
    return w;
  endfunction

  task automatic feed4(input int off, input int gaps, input string tag);
    int pulses, eofs;
    bit have;
    logic [71:0] last;
    pulses = 0; eofs = 0; have = 0; last = '0;
    for (int k = 0; k < 16; k++) begin
      int r, c;
      bit ev;
      r = k / 4; c = k % 4;
      ev = (r >= 2) && (c >= 2);
      step(0, 1'b1, 8'(off + k));
      chk($sformatf("%s val k=%0d", tag, k), 72'(vo4), 72'(ev));
      chk($sformatf("%s eof k=%0d", tag, k), 72'(eo4), 72'(k == 15));
      if (vo4) pulses++;
      if (eo4) eofs++;
      if (ev) begin
        last = exp4(off + k - 10);
        chk($sformatf("%s win k=%0d", tag, k), w4, last);
      end
      have = ev;
      for (int g = 0; g < gaps; g++) begin
        step(0, 1'b0, 8'hEE);
        chk($sformatf("%s gap val k=%0d", tag, k), 72'(vo4), 72'd0);
        if (have) chk($sformatf("%s gap win k=%0d", tag, k), w4, last);
      end
    end
    chk({tag, " pulses"}, 72'(pulses), 72'd4);
    chk({tag, " eofs"}, 72'(eofs), 72'd1);
  endtask

  initial begin
    logic [7:0] fr [6][5];
    int wins, eofs;

    #1;
    chk("reset win4", w4, 72'd0);
    chk("reset val4", 72'(vo4), 72'd0);
    chk("reset eof4", 72'(eo4), 72'd0);
    chk("reset win56", w5, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame, then gapped frame, then two back-to-back frames.
    feed4(0, 0, "cont");
    feed4(0, 2, "gap");
    feed4(0, 0, "b2b0");
    feed4(100, 0, "b2b1");
    chk("frame2 first win literal", exp4(100),
        {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});

    // Reset after pixel 9, with val_i held high during reset.
    for (int k = 0; k < 10; k++) step(0, 1'b1, 8'(k));
    @(negedge clk);
    rst_n = 1'b0; v4 = 1'b1; d4 = 8'd77;
    #1;
    chk("rst async val", 72'(vo4), 72'd0);
    chk("rst async win", w4, 72'd0);
    @(posedge clk);
    #1;
    chk("rst held val", 72'(vo4), 72'd0);
    chk("rst held eof", 72'(eo4), 72'd0);
    @(negedge clk);
    rst_n = 1'b1; v4 = 1'b0;
    feed4(0, 0, "postrst");

    // Random pixels with random gaps on the 5x6 instance, two frames.
    for (int f = 0; f < 2; f++) begin
      wins = 0; eofs = 0;
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 5; c++) begin
          bit ev;
          logic [71:0] ew;
          fr[r][c] = 8'($urandom_range(0, 255));
          step(1, 1'b1, fr[r][c]);
          ev = (r >= 2) && (c >= 2);
          chk($sformatf("r56 val f%0d (%0d,%0d)", f, r, c), 72'(vo5), 72'(ev));
          chk($sformatf("r56 eof f%0d (%0d,%0d)", f, r, c), 72'(eo5), 72'(r == 5 && c == 4));
          if (vo5) wins++;
          if (eo5) eofs++;
          if (ev) begin
            ew = '0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                ew[8*(3*i+j) +: 8] = fr[r-2+i][c-2+j];
            chk($sformatf("r56 win f%0d (%0d,%0d)", f, r, c), w5, ew);
          end
          repeat ($urandom_range(0, 2)) begin
            step(1, 1'b0, 8'($urandom_range(0, 255)));
            chk("r56 gap val", 72'(vo5), 72'd0);
          end
        end
      end
      chk($sformatf("r56 wins f%0d", f), 72'(wins), 72'd12);
      chk($sformatf("r56 eofs f%0d", f), 72'(eofs), 72'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
